// File: rtl/decode_pkg.sv
// decode_pkg: ISA constants, format classes and the decoded-bundle type shared by the decode stage.
package decode_pkg;
    localparam int PKG_INSTR_W = 32;
    localparam int PKG_OPC_W   = 6;
    localparam int PKG_REG_W   = 5;
    localparam int PKG_ADDR_W  = 8;
    localparam int PKG_IMM_W   = 16;
    localparam int PKG_ALU_LO  = 4;
    localparam int PKG_ALU_HI  = 16;
    localparam int PKG_CNT_W   = 16;
    typedef enum logic [2:0] {
        FMT_LDI = 3'd0,
        FMT_MOV = 3'd1,
        FMT_LD  = 3'd2,
        FMT_ST  = 3'd3,
        FMT_ALU = 3'd4,
        FMT_ILL = 3'd7
    } fmt_e;
    localparam logic [PKG_OPC_W-1:0] OP_LDI = PKG_OPC_W'(0);
    localparam logic [PKG_OPC_W-1:0] OP_MOV = PKG_OPC_W'(1);
    localparam logic [PKG_OPC_W-1:0] OP_LD  = PKG_OPC_W'(2);
    localparam logic [PKG_OPC_W-1:0] OP_ST  = PKG_OPC_W'(3);
    typedef struct packed {
        logic [PKG_OPC_W-1:0]  opcode;
        fmt_e                  fmt;
        logic                  illegal;
        logic [PKG_REG_W-1:0]  rdst2;
        logic [PKG_REG_W-1:0]  rdst1;
        logic [PKG_REG_W-1:0]  rsrc2;
        logic [PKG_REG_W-1:0]  rsrc1;
        logic [PKG_ADDR_W-1:0] src_addr;
        logic [PKG_ADDR_W-1:0] dst_addr;
        logic [PKG_IMM_W-1:0]  imm;
    } dec_s;
endpackage

// File: rtl/decode_fields.sv
// decode_fields: combinational split of one instruction word into a decoded bundle;
// fields a format does not use are forced to zero.
module decode_fields import decode_pkg::*; #(
    parameter int INSTR_W = PKG_INSTR_W,
    parameter int OPC_W   = PKG_OPC_W,
    parameter int REG_W   = PKG_REG_W,
    parameter int ADDR_W  = PKG_ADDR_W,
    parameter int IMM_W   = PKG_IMM_W,
    parameter int ALU_LO  = PKG_ALU_LO,
    parameter int ALU_HI  = PKG_ALU_HI
) (
    input  logic [INSTR_W-1:0] i_instr,
    output dec_s               o_dec
);
    localparam int D = INSTR_W - OPC_W;
    logic [OPC_W-1:0] w_opc;
    logic             w_alu;
    assign w_opc = i_instr[INSTR_W-1 -: OPC_W];
    assign w_alu = (w_opc >= OPC_W'(ALU_LO)) && (w_opc <= OPC_W'(ALU_HI));
    always_comb begin
        o_dec        = '0;
        o_dec.opcode = w_opc;
        if (w_opc == OP_LDI) begin
            o_dec.fmt   = FMT_LDI;
            o_dec.rdst2 = i_instr[D-1 -: REG_W];
            o_dec.imm   = i_instr[IMM_W-1:0];
        end else if (w_opc == OP_MOV) begin
            o_dec.fmt   = FMT_MOV;
            o_dec.rdst2 = i_instr[D-1 -: REG_W];
            o_dec.rsrc2 = i_instr[2*REG_W-1:REG_W];
        end else if (w_opc == OP_LD) begin
            o_dec.fmt      = FMT_LD;
            o_dec.rdst2    = i_instr[D-1 -: REG_W];
            o_dec.src_addr = i_instr[ADDR_W-1:0];
        end else if (w_opc == OP_ST) begin
            o_dec.fmt      = FMT_ST;
            o_dec.dst_addr = i_instr[D-1 -: ADDR_W];
            o_dec.rsrc2    = i_instr[2*REG_W-1:REG_W];
        end else if (w_alu) begin
            o_dec.fmt   = FMT_ALU;
            o_dec.rdst2 = i_instr[D-1 -: REG_W];
            o_dec.rdst1 = i_instr[D-REG_W-1 -: REG_W];
            o_dec.rsrc2 = i_instr[2*REG_W-1:REG_W];
            o_dec.rsrc1 = i_instr[REG_W-1:0];
        end else begin
            o_dec.fmt     = FMT_ILL;
            o_dec.illegal = 1'b1;
        end
    end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered decode pipeline stage, main register plus one skid entry,
// valid/ready on both sides, flush, and a saturating count of output handshakes.
module decode_stage import decode_pkg::*; #(
    parameter int INSTR_W = PKG_INSTR_W,
    parameter int OPC_W   = PKG_OPC_W,
    parameter int REG_W   = PKG_REG_W,
    parameter int ADDR_W  = PKG_ADDR_W,
    parameter int IMM_W   = PKG_IMM_W,
    parameter int ALU_LO  = PKG_ALU_LO,
    parameter int ALU_HI  = PKG_ALU_HI,
    parameter int CNT_W   = PKG_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OPC_W-1:0]   out_opcode,
    output fmt_e               out_fmt,
    output logic               out_illegal,
    output logic [REG_W-1:0]   out_rdst2,
    output logic [REG_W-1:0]   out_rdst1,
    output logic [REG_W-1:0]   out_rsrc2,
    output logic [REG_W-1:0]   out_rsrc1,
    output logic [ADDR_W-1:0]  out_src_addr,
    output logic [ADDR_W-1:0]  out_dst_addr,
    output logic [IMM_W-1:0]   out_imm,
    output logic [CNT_W-1:0]   out_count
);
    dec_s             w_dec;
    dec_s             r_main;
    dec_s             r_skid;
    logic             r_main_v;
    logic             r_skid_v;
    logic             w_acc;
    logic             w_hs;
    logic [CNT_W-1:0] r_count;
    decode_fields #(
        .INSTR_W(INSTR_W), .OPC_W(OPC_W), .REG_W(REG_W), .ADDR_W(ADDR_W),
        .IMM_W(IMM_W), .ALU_LO(ALU_LO), .ALU_HI(ALU_HI)
    ) u_fields (
        .i_instr(in_instr),
        .o_dec  (w_dec)
    );
    assign w_acc = in_valid && !r_skid_v;
    assign w_hs  = r_main_v && out_ready;
    // Skid fills only while main is stalled, so it always drains into main before new input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main   <= '0;
            r_skid   <= '0;
            r_main_v <= 1'b0;
            r_skid_v <= 1'b0;
            r_count  <= '0;
        end else if (flush) begin
            r_main_v <= 1'b0;
            r_skid_v <= 1'b0;
        end else begin
            if (w_hs && r_count != '1) r_count <= r_count + 1'b1;
            if (!r_main_v || w_hs) begin
                r_main_v <= r_skid_v || w_acc;
                r_skid_v <= 1'b0;
                if (r_skid_v) r_main <= r_skid;
                else if (w_acc) r_main <= w_dec;
            end else if (w_acc) begin
                r_skid_v <= 1'b1;
                r_skid   <= w_dec;
            end
        end
    end
    assign in_ready     = !r_skid_v;
    assign out_valid    = r_main_v;
    assign out_opcode   = r_main.opcode;
    assign out_fmt      = r_main.fmt;
    assign out_illegal  = r_main.illegal;
    assign out_rdst2    = r_main.rdst2;
    assign out_rdst1    = r_main.rdst1;
    assign out_rsrc2    = r_main.rsrc2;
    assign out_rsrc1    = r_main.rsrc1;
    assign out_src_addr = r_main.src_addr;
    assign out_dst_addr = r_main.dst_addr;
    assign out_imm      = r_main.imm;
    assign out_count    = r_count;
endmodule
